// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   UART_OVERSAMPLE : samples per bit
//   uart_div()      : clocks per oversample tick, rounded to nearest
// Build option: UART_RX_PARITY_EN adds the PARITY state (8-E-1 frames).
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } uart_rx_state_t;

    function automatic int uart_div(input int clk, input int baud, input int os);
        return (clk + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive FIFO with a registered head output.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (dropped when full unless popping)
//   ready    : consumer accepts dout when valid
//   dout     : registered head of the FIFO
//   valid    : FIFO not empty
//   overrun  : one-cycle pulse when a push is dropped
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp, rp_next;
    logic             empty, full, pop, push_ok;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign valid   = !empty;
    assign pop     = valid && ready;
    assign push_ok = push && (!full || pop);
    assign rp_next = rp + 1'b1;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp_next;
            // Head register: after a pop the new head is either still in RAM
            // or is the byte being written this very cycle.
            if (pop) begin
                if (rp_next != wp)
                    dout <= mem[rp_next[AW-1:0]];
                else if (push_ok)
                    dout <= din;
            end else if (push_ok && empty) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with byte FIFO and valid/ready output.
//   clk_i, rst_i : fabric clock, asynchronous active-high reset
//   rxd_i        : asynchronous serial line, idles high
//   data_o       : byte at FIFO head (registered)
//   valid_o      : FIFO not empty; ready_i pops
//   frame_err_o  : pulse, stop bit sampled low
//   overrun_o    : pulse, good byte dropped on full FIFO
//   parity_err_o : pulse, parity mismatch (0 unless UART_RX_PARITY_EN)
// Build option: UART_RX_PARITY_EN selects 8-E-1 framing.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge
// S_START | validating the start bit (majority 1 = glitch)
// S_DATA  | shifting in 8 data bits, LSB first
// S_PARITY| checking even parity (parity builds only)
// S_STOP  | mid-stop decision: push, frame error or parity error
// S_BREAK | line held low after a frame error, wait for high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [3:0]    OS_LAST   = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state, state_nxt;
    logic                      rxd_meta, rxd_sync;
    logic [CW-1:0]             tick_cnt;
    logic [3:0]                os;
    logic                      samp7, samp8, maj;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_cnt;
    logic                      tick, bit_dec, bit_end;
    logic                      start_go, push, frame_err_nxt;

    assign tick    = (tick_cnt == TICK_LAST);
    assign bit_dec = tick && (os == 4'd9);
    assign bit_end = tick && (os == OS_LAST);
    // Majority of samples 7, 8 and the live sample 9.
    assign maj = (samp7 & samp8) | (samp7 & rxd_sync) | (samp8 & rxd_sync);

`ifdef UART_RX_PARITY_EN
    logic par_flag, parity_err_nxt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        start_go      = 1'b0;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_nxt = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxd_sync) begin
                    start_go  = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_dec && maj)
                    state_nxt = S_IDLE;
                else if (bit_end)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end)
                    state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so an immediately following start edge is caught.
                if (bit_dec) begin
                    if (!maj) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_BREAK;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_flag) begin
                        parity_err_nxt = 1'b1;
                        state_nxt      = S_IDLE;
                    end
`endif
                    else begin
                        push      = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rxd_sync)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
            os       <= '0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            // Clearing on the start edge aligns sampling phase to the frame.
            if (start_go) begin
                tick_cnt <= '0;
                os       <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick)
                    os <= os + 4'd1;
                if (tick && os == 4'd7)
                    samp7 <= rxd_sync;
                if (tick && os == 4'd8)
                    samp8 <= rxd_sync;
            end
            if (state == S_DATA && bit_dec)
                shift <= {maj, shift[UART_DATA_BITS-1:1]};
            if (state == S_START)
                bit_cnt <= '0;
            else if (state == S_DATA && bit_end)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            frame_err_o <= 1'b0;
        else
            frame_err_o <= frame_err_nxt;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_flag     <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= parity_err_nxt;
            if (start_go)
                par_flag <= 1'b0;
            else if (state == S_PARITY && bit_dec)
                par_flag <= maj ^ (^shift);
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .din     (shift),
        .ready   (ready_i),
        .dout    (data_o),
        .valid   (valid_o),
        .overrun (overrun_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, run at a reduced clock/baud ratio
// (DIV = 4, 64 clocks per bit) to keep frame times short.
// Build option: UART_RX_PARITY_EN enables the parity frames and checks.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 16 * 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr, perr;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rxd_i        (rxd),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .parity_err_o (perr)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    int         n_ferr, n_ovr, n_perr;
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) rx_q.push_back(data);
            if (ferr) n_ferr++;
            if (ovr)  n_ovr++;
            if (perr) n_perr++;
        end
    end

    function automatic logic [31:0] q_at(input int i);
        return (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(BIT);
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(1'b1);
    endtask
`endif

    task automatic clr();
        rx_q.delete();
        n_ferr = 0;
        n_ovr  = 0;
        n_perr = 0;
    endtask

    initial begin
        logic [7:0] f0;
        f0 = 8'hF0;
        clr();
        wait_clk(3);

        check("rst_data",  {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'h0);
        check("rst_ferr",  {31'd0, ferr}, 32'h0);
        check("rst_ovr",   {31'd0, ovr}, 32'h0);
        check("rst_perr",  {31'd0, perr}, 32'h0);
        check("div_default", uart_div(100_000_000, 115200, 16), 32'd54);
        check("div_bench",   uart_div(CLK_FREQ, BAUD, 16), 32'd4);
        rst = 1'b0;
        wait_clk(BIT);

        // two back-to-back bytes, consumer always ready
        clr();
        ready = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        wait_clk(BIT);
        check("t1_count", rx_q.size(), 32'd2);
        check("t1_b0", q_at(0), 32'h55);
        check("t1_b1", q_at(1), 32'hA3);
        check("t1_ferr", n_ferr, 32'd0);
        check("t1_ovr",  n_ovr, 32'd0);
        check("t1_perr", n_perr, 32'd0);

        // fill the FIFO past capacity
        clr();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1);
        wait_clk(BIT);
        check("t2_valid", {31'd0, valid}, 32'h1);
        check("t2_head",  {24'd0, data}, 32'h0);
        check("t2_ovr",   n_ovr, 32'd2);
        ready = 1'b1;
        wait_clk(20);
        check("t2_count", rx_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t2_b%0d", i), q_at(i), 32'(i));
        check("t2_empty", {31'd0, valid}, 32'h0);

        // stop bit low, then a held-low line
        clr();
        send_frame(8'h3C, 1'b0);
        wait_clk(3 * 10 * BIT);
        check("t3_ferr_once", n_ferr, 32'd1);
        check("t3_no_push", rx_q.size(), 32'd0);
        rxd = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h7E, 1'b1);
        wait_clk(BIT);
        check("t3_count", rx_q.size(), 32'd1);
        check("t3_b0", q_at(0), 32'h7E);
        check("t3_ferr_total", n_ferr, 32'd1);

        // short low glitch on idle line
        clr();
        rxd = 1'b0;
        wait_clk(12);
        rxd = 1'b1;
        wait_clk(2 * BIT);
        check("t4_glitch_none", rx_q.size(), 32'd0);
        check("t4_glitch_ferr", n_ferr, 32'd0);
        send_frame(8'h81, 1'b1);
        wait_clk(BIT);
        check("t4_count", rx_q.size(), 32'd1);
        check("t4_b0", q_at(0), 32'h81);

        // reset in the middle of data bit 4
        clr();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(f0[i]);
        rxd = f0[4];
        wait_clk(BIT / 2);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        rxd = 1'b1;
        wait_clk(3 * BIT);
        check("t5_valid_low", {31'd0, valid}, 32'h0);
        check("t5_no_push", rx_q.size(), 32'd0);
        send_frame(8'h0F, 1'b1);
        wait_clk(BIT);
        check("t5_count", rx_q.size(), 32'd1);
        check("t5_b0", q_at(0), 32'h0F);
        check("t5_ferr", n_ferr, 32'd0);

`ifdef UART_RX_PARITY_EN
        clr();
        send_frame_par(8'h07, 1'b1);
        wait_clk(BIT);
        check("t6_good_count", rx_q.size(), 32'd1);
        check("t6_good_b0", q_at(0), 32'h07);
        check("t6_good_perr", n_perr, 32'd0);
        clr();
        send_frame_par(8'h07, 1'b0);
        wait_clk(BIT);
        check("t6_bad_perr", n_perr, 32'd1);
        check("t6_bad_none", rx_q.size(), 32'd0);
`else
        check("t6_perr_tied", n_perr, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
